// File: rtl/alu_serial_gen.sv
// rtl/alu_serial_gen.sv - serial-framed ALU: frame receiver, CRC/opcode checks, single-cycle compute, response serialiser
module alu_serial_gen #(
  parameter int DATA_W = 32,
  parameter bit EN_XOR = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sin,
  output logic sout
);
  localparam int N   = DATA_W / 8;
  localparam int DCW = $clog2(2 * N + 1);
  localparam int OPW = 2 * DATA_W;
  localparam logic [DCW-1:0] DFULL = DCW'(2 * N);

  typedef enum logic [1:0] {IDLE, RX_BITS, CHECK, TX} state_t;

  state_t            state_q;
  logic              armed_q;
  logic [3:0]        bit_cnt_q;
  logic [9:0]        rx_sh_q;
  logic [DCW-1:0]    dcnt_q;
  logic [OPW-1:0]    ops_q;
  logic [3:0]        crc4_q;
  logic [DATA_W-1:0] res_q;
  logic [7:0]        ctl_pl_q;
  logic [DCW-1:0]    data_left_q;
  logic              ctl_pend_q;
  logic [10:0]       tx_sh_q;
  logic              sout_q;

  logic [9:0]        rx_sh_d;
  logic              rx_cmd, rx_stop;
  logic [7:0]        rx_pl;
  logic [2:0]        rx_op;
  logic [3:0]        rx_crc;
  logic [DATA_W-1:0] opb, opa;
  logic [DATA_W:0]   add_w, sub_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry, alu_ovfl;
  logic [3:0]        alu_flags;
  logic [3:0]        crc4_fin;
  logic [2:0]        crc3_fin;
  logic              op_legal;
  logic              err_data, err_crc, err_op;
  logic [2:0]        err;
  logic [7:0]        err_pl, ok_pl;

  // x^4+x+1, MSB first, over the low nb bits of d
  function automatic logic [3:0] crc4_upd(input logic [3:0] c, input logic [7:0] d, input int nb);
    logic [3:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (i < nb) begin
        fb = r[3] ^ d[i];
        r  = {r[2:1], r[0] ^ fb, fb};
      end
    end
    return r;
  endfunction

  // x^3+x+1, MSB first, init 0, over {result, flags}
  function automatic logic [2:0] crc3_calc(input logic [DATA_W+3:0] m);
    logic [2:0] r;
    logic       fb;
    r = '0;
    for (int i = DATA_W + 3; i >= 0; i--) begin
      fb = r[2] ^ m[i];
      r  = {r[1], r[0] ^ fb, fb};
    end
    return r;
  endfunction

  assign rx_sh_d = {rx_sh_q[8:0], sin};
  assign sout    = sout_q;

  always_comb begin
    rx_cmd  = rx_sh_q[9];
    rx_pl   = rx_sh_q[8:1];
    rx_op   = rx_sh_q[7:5];
    rx_crc  = rx_sh_q[4:1];
    rx_stop = rx_sh_q[0];
    opb     = ops_q[OPW-1:DATA_W];
    opa     = ops_q[DATA_W-1:0];
    add_w   = {1'b0, opb} + {1'b0, opa};
    sub_w   = {1'b0, opb} - {1'b0, opa};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovfl  = 1'b0;
    case (rx_op)
      3'b000: alu_res = opb & opa;
      3'b001: alu_res = opb | opa;
      3'b010: alu_res = opb ^ opa;
      3'b100: begin
        alu_res   = add_w[DATA_W-1:0];
        alu_carry = add_w[DATA_W];
        alu_ovfl  = (opb[DATA_W-1] == opa[DATA_W-1]) && (alu_res[DATA_W-1] != opb[DATA_W-1]);
      end
      3'b101: begin
        alu_res   = sub_w[DATA_W-1:0];
        alu_carry = sub_w[DATA_W];
        alu_ovfl  = (opb[DATA_W-1] != opa[DATA_W-1]) && (alu_res[DATA_W-1] != opb[DATA_W-1]);
      end
      default: alu_res = '0;
    endcase
    alu_flags = {alu_carry, alu_ovfl, (alu_res == '0), alu_res[DATA_W-1]};

    case (rx_op)
      3'b000, 3'b001, 3'b100, 3'b101: op_legal = 1'b1;
      3'b010:                         op_legal = EN_XOR;
      default:                        op_legal = 1'b0;
    endcase

    crc4_fin = crc4_upd(crc4_q, {4'b0000, 1'b1, rx_op}, 4);
    crc3_fin = crc3_calc({alu_res, alu_flags});

    // Priority DATA > CRC > OP so that exactly one error bit is raised
    err_data = !rx_stop || (rx_cmd ? (dcnt_q != DFULL) : (dcnt_q == DFULL));
    err_crc  = !err_data && rx_cmd && (crc4_fin != rx_crc);
    err_op   = !err_data && !err_crc && rx_cmd && !op_legal;
    err      = {err_data, err_crc, err_op};
    err_pl   = {1'b1, err, err, ^{1'b1, err, err}};
    ok_pl    = {1'b0, alu_flags, crc3_fin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      dcnt_q      <= '0;
      ops_q       <= '0;
      crc4_q      <= '0;
      res_q       <= '0;
      ctl_pl_q    <= '0;
      data_left_q <= '0;
      ctl_pend_q  <= 1'b0;
      tx_sh_q     <= '1;
      sout_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sout_q <= 1'b1;
          if (!armed_q) begin
            armed_q <= sin;
          end else if (!sin) begin
            state_q   <= RX_BITS;
            bit_cnt_q <= '0;
          end
        end
        RX_BITS: begin
          sout_q    <= 1'b1;
          rx_sh_q   <= rx_sh_d;
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_q <= CHECK;
        end
        CHECK: begin
          sout_q <= 1'b1;
          if (err != 3'b000 || rx_cmd) begin
            if (err != 3'b000) begin
              tx_sh_q     <= {2'b01, err_pl, 1'b1};
              data_left_q <= '0;
              ctl_pend_q  <= 1'b0;
            end else begin
              tx_sh_q     <= {2'b00, alu_res[DATA_W-1 -: 8], 1'b1};
              res_q       <= alu_res << 8;
              data_left_q <= DCW'(N - 1);
              ctl_pl_q    <= ok_pl;
              ctl_pend_q  <= 1'b1;
            end
            dcnt_q    <= '0;
            ops_q     <= '0;
            crc4_q    <= '0;
            bit_cnt_q <= '0;
            state_q   <= TX;
          end else begin
            ops_q  <= {ops_q[OPW-9:0], rx_pl};
            dcnt_q <= dcnt_q + 1'b1;
            crc4_q <= crc4_upd(crc4_q, rx_pl, 8);
            // A start bit may follow the stop bit directly while we sit here
            if (!sin) begin
              state_q   <= RX_BITS;
              bit_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        TX: begin
          sout_q <= tx_sh_q[10];
          if (bit_cnt_q == 4'd10) begin
            bit_cnt_q <= '0;
            if (data_left_q != '0) begin
              tx_sh_q     <= {2'b00, res_q[DATA_W-1 -: 8], 1'b1};
              res_q       <= res_q << 8;
              data_left_q <= data_left_q - 1'b1;
            end else if (ctl_pend_q) begin
              tx_sh_q    <= {2'b01, ctl_pl_q, 1'b1};
              ctl_pend_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              armed_q <= 1'b0;
            end
          end else begin
            tx_sh_q   <= {tx_sh_q[9:0], 1'b1};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_gen.sv
// tb/tb_alu_serial_gen.sv - scoreboard bench for alu_serial_gen (32-bit, 8-bit with and without XOR)
module tb_alu_serial_gen;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sin_v = '1;
  logic [2:0] sout_v;
  int         cyc      = 0;
  int         checks   = 0;
  int         failures = 0;
  bit         mon_busy [3];
  bit         drop     [3];

  typedef struct {
    int         idx;
    int         t;
    logic [8:0] fr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_serial_gen #(.DATA_W(32), .EN_XOR(1'b1)) u_w32 (.clk(clk), .rst_n(rst_n), .sin(sin_v[0]), .sout(sout_v[0]));
  alu_serial_gen #(.DATA_W(8),  .EN_XOR(1'b1)) u_w8x (.clk(clk), .rst_n(rst_n), .sin(sin_v[1]), .sout(sout_v[1]));
  alu_serial_gen #(.DATA_W(8),  .EN_XOR(1'b0)) u_w8n (.clk(clk), .rst_n(rst_n), .sin(sin_v[2]), .sout(sout_v[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder of M(x)*x^n mod P(x) by long division
  function automatic logic [3:0] crc_div(input logic [127:0] msg, input int len, input logic [4:0] poly, input int n);
    logic [4:0] rem;
    rem = '0;
    for (int i = len - 1; i >= 0; i--) begin
      rem = {rem[3:0], msg[i]};
      if (rem[n]) rem = rem ^ poly;
    end
    for (int i = 0; i < n; i++) begin
      rem = {rem[3:0], 1'b0};
      if (rem[n]) rem = rem ^ poly;
    end
    return rem[3:0];
  endfunction

  task automatic push_exp(input int idx, input int t, input logic [8:0] fr);
    exp_t e;
    e.idx = idx;
    e.t   = t;
    e.fr  = fr;
    sb.push_back(e);
  endtask

  task automatic exp_ok(input int idx, input int w, input logic [31:0] res, input logic [3:0] flags);
    int           nb;
    logic [127:0] m;
    logic [3:0]   c;
    nb = w / 8;
    m  = ({96'b0, res} << 4) | {124'b0, flags};
    c  = crc_div(m, w + 4, 5'b01011, 3);
    for (int i = 0; i < nb; i++) push_exp(idx, cyc + 2 + 11 * i, {1'b0, res[8*(nb-1-i) +: 8]});
    push_exp(idx, cyc + 2 + 11 * nb, {1'b1, 1'b0, flags, c[2:0]});
  endtask

  task automatic exp_err(input int idx, input logic [7:0] pl);
    push_exp(idx, cyc + 2, {1'b1, pl});
  endtask

  task automatic flush(input int idx);
    for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].idx == idx) sb.delete(k);
  endtask

  task automatic send_bit(input int idx, input logic b);
    sin_v[idx] = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int idx, input logic cmd, input logic [7:0] pl, input logic stop = 1'b1);
    send_bit(idx, 1'b0);
    send_bit(idx, cmd);
    for (int i = 7; i >= 0; i--) send_bit(idx, pl[i]);
    send_bit(idx, stop);
    sin_v[idx] = 1'b1;
  endtask

  task automatic run_op(input int idx, input int w, input logic [31:0] b, input logic [31:0] a,
                        input logic [2:0] op, input logic [3:0] crc_xor);
    logic [127:0] msg;
    logic [3:0]   c;
    int           nb;
    nb  = w / 8;
    msg = ({96'b0, b} << (w + 4)) | ({96'b0, a} << 4) | {124'b0, 1'b1, op};
    c   = crc_div(msg, 2 * w + 4, 5'b10011, 4) ^ crc_xor;
    for (int i = nb - 1; i >= 0; i--) send_frame(idx, 1'b0, b[8*i +: 8]);
    for (int i = nb - 1; i >= 0; i--) send_frame(idx, 1'b0, a[8*i +: 8]);
    send_frame(idx, 1'b1, {1'b0, op, c});
  endtask

  task automatic wait_idle(input int idx);
    int n;
    bit pending;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      pending = mon_busy[idx];
      foreach (sb[k]) if (sb[k].idx == idx) pending = 1'b1;
    end while (pending && n < 200);
    check($sformatf("drain_dut%0d", idx), pending, 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic mon(input int idx);
    int         t0;
    int         hit;
    logic [9:0] f;
    forever begin
      @(negedge clk);
      if (rst_n && sout_v[idx] === 1'b0) begin
        mon_busy[idx] = 1'b1;
        t0 = cyc;
        for (int i = 9; i >= 0; i--) begin
          @(negedge clk);
          f[i] = sout_v[idx];
        end
        if (!drop[idx]) begin
          hit = -1;
          foreach (sb[k]) if (hit < 0 && sb[k].idx == idx) hit = k;
          if (hit < 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame dut%0d: got %03h at cycle %0d, none expected", idx, f, t0);
          end else begin
            check($sformatf("frame_time_dut%0d", idx), t0, sb[hit].t);
            check($sformatf("frame_bits_dut%0d", idx), f, {sb[hit].fr, 1'b1});
            sb.delete(hit);
          end
        end
        mon_busy[idx] = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sout_w32", sout_v[0], 1'b1);
    check("reset_sout_w8x", sout_v[1], 1'b1);
    check("reset_sout_w8n", sout_v[2], 1'b1);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // ADD with signed overflow; a stray frame during TX must be ignored
    run_op(0, 32, 32'h7FFF_FFFF, 32'h0000_0001, 3'b100, 4'h0);
    exp_ok(0, 32, 32'h8000_0000, 4'b0101);
    repeat (10) @(posedge clk);
    #1;
    send_frame(0, 1'b0, 8'hAA);
    wait_idle(0);

    run_op(0, 32, 32'h0000_0003, 32'h0000_0005, 3'b101, 4'h0);
    exp_ok(0, 32, 32'hFFFF_FFFE, 4'b1001);
    wait_idle(0);

    run_op(0, 32, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 4'h0);
    exp_ok(0, 32, 32'h0000_0000, 4'b1010);
    wait_idle(0);

    // Short operand sequence: CTL after 7 DATA frames
    for (int i = 0; i < 7; i++) send_frame(0, 1'b0, 8'(8'h11 * i));
    send_frame(0, 1'b1, 8'h45);
    exp_err(0, 8'hC9);
    wait_idle(0);

    run_op(0, 32, 32'h1234_5678, 32'h0F0F_0F0F, 3'b100, 4'h1);
    exp_err(0, 8'hA5);
    wait_idle(0);

    run_op(0, 32, 32'h1234_5678, 32'h0F0F_0F0F, 3'b011, 4'h0);
    exp_err(0, 8'h93);
    wait_idle(0);

    run_op(0, 32, 32'h1234_5678, 32'h0F0F_0F0F, 3'b011, 4'h1);
    exp_err(0, 8'hA5);
    wait_idle(0);

    // Surplus 9th DATA frame is reported without waiting for CTL
    for (int i = 0; i < 9; i++) send_frame(0, 1'b0, 8'(8'h21 + i));
    exp_err(0, 8'hC9);
    wait_idle(0);

    send_frame(0, 1'b0, 8'h12);
    send_frame(0, 1'b0, 8'h34, 1'b0);
    exp_err(0, 8'hC9);
    wait_idle(0);

    run_op(0, 32, 32'h0000_0005, 32'h0000_0007, 3'b001, 4'h0);
    exp_ok(0, 32, 32'h0000_0007, 4'b0000);
    wait_idle(0);

    // Reset asserted while a response start bit is on sout
    run_op(0, 32, 32'h0000_0005, 32'h0000_0003, 3'b000, 4'h0);
    n = 0;
    while (sout_v[0] !== 1'b0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tx_started_before_reset", sout_v[0], 1'b0);
    drop[0] = 1'b1;
    flush(0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_during_tx", sout_v[0], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    drop[0] = 1'b0;

    // Reset part-way through the 5th operand frame
    for (int i = 0; i < 4; i++) send_frame(0, 1'b0, 8'h5A);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_rx", sout_v[0], 1'b1);
    sin_v[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_op(0, 32, 32'hFFFF_0000, 32'h00FF_FF00, 3'b000, 4'h0);
    exp_ok(0, 32, 32'h00FF_0000, 4'b0000);
    wait_idle(0);

    run_op(1, 8, 32'hF0, 32'hFF, 3'b010, 4'h0);
    exp_ok(1, 8, 32'h0F, 4'b0000);
    wait_idle(1);

    run_op(1, 8, 32'h80, 32'h01, 3'b101, 4'h0);
    exp_ok(1, 8, 32'h7F, 4'b0100);
    wait_idle(1);

    run_op(2, 8, 32'hF0, 32'hFF, 3'b010, 4'h0);
    exp_err(2, 8'h93);
    wait_idle(2);

    run_op(2, 8, 32'h0F, 32'h30, 3'b001, 4'h0);
    exp_ok(2, 8, 32'h3F, 4'b0000);
    wait_idle(2);

    run_op(2, 8, 32'h80, 32'h80, 3'b100, 4'h0);
    exp_ok(2, 8, 32'h00, 4'b1110);
    wait_idle(2);

    repeat (30) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_serial_gen.md
# alu_serial_gen

Parametrised serial-framed ALU, the next generation of the team's 8-bit-framed serial ALU. It deserialises operand and control frames from `sin`, checks framing, CRC and opcode, and computes `B op A` at `DATA_W` bits. It then serialises either a result-plus-flags response or an error frame on `sout`. It sits between the serial link and the testbench or host agent, and keeps the existing frame format so the current drivers and monitors stay in use.

## Interface
- `DATA_W`, default 32: operand/result width; must be `8*N`, `N >= 1`.
- `EN_XOR`, default 1: when 1, opcode `3'b010` (XOR) is legal; when 0 it is an illegal opcode.
- `clk`  in  1: single clock, all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sin`  in  1: serial input; idles at 1; one bit sampled per `clk`.
- `sout`  out  1: serial output; idles at 1; one bit driven per `clk`.

## Operation
- **Frame format:** 11 bits, MSB first: start `0`, cmd bit (`0` = DATA, `1` = CTL), 8 payload bits, stop `1`.
- **Input sequence:** `N` DATA frames of B (MSB byte first), then `N` DATA frames of A, then one CTL frame with payload `{1'b0, op[2:0], crc4[3:0]}`.
- **Opcodes:** AND `000`, OR `001`, XOR `010` (`EN_XOR` only), ADD `100`, SUB `101`; SUB computes `B - A`.
- **Input CRC:** `crc4` is computed over `{B, A, 1'b1, op}` MSB first, polynomial x^4+x+1, init 0.
- **Receiver FSM:** `IDLE -> RX_BITS -> CHECK -> (TX | IDLE)`.
  - `IDLE` waits for `sin=0`.
  - `RX_BITS` shifts 10 more bits, then stores the payload and increments `dcnt` (width `clog2(2N+1)`).
- **Error detection, exactly one error bit reported, priority DATA > CRC > OP:**
  - ERRDATA: stop bit = 0, a CTL frame arriving with `dcnt != 2N`, or a (2N+1)th DATA frame.
  - ERRCRC: `crc4` mismatch.
  - ERROP: illegal opcode.
- **ERRDATA timing:** on a surplus DATA frame or a bad stop bit, the error is reported immediately; no wait for CTL.
- **Result flags** `{carry, ovfl, zero, neg}`:
  - ADD: carry = carry-out of bit `DATA_W-1`.
  - SUB: carry = borrow (`B < A` unsigned).
  - ADD/SUB: ovfl = signed two's-complement overflow.
  - Logic ops: carry = ovfl = 0.
  - zero = (result == 0); neg = `result[DATA_W-1]`.
- **OK response:** `N` DATA frames of the result (MSB byte first), then a CTL frame with payload `{1'b0, flags[3:0], crc3[2:0]}`.
  - `crc3` is computed over `{result, flags}`, polynomial x^3+x+1, init 0.
- **Error response:** one CTL frame with payload `{1'b1, err[2:0], err[2:0], parity}`.
  - `err = {data, crc, op}`.
  - `parity` = even parity over the preceding 7 payload bits.
- **After any response:** `dcnt`, operand registers and CRC accumulators are cleared.
- **Frames during TX:** `sin` frames arriving while TX is active are discarded entirely. The receiver re-arms only after the last stop bit is sent and `sin` has been 1 for at least one cycle.

## Timing
- **Reset:** `rst_n` low forces `sout=1`, FSM to `IDLE`, and `dcnt=0` immediately, independent of `clk`.
  - An operation in progress is abandoned; no partial response is sent.
  - Release takes effect on the first `clk` edge with `rst_n=1`.
- **Latency:** the first start bit on `sout` is driven 2 cycles after the cycle in which the CTL stop bit (or offending frame) is sampled. Compute is a single cycle in `CHECK`.
- **Response length:** OK responses are sent back-to-back with no idle gap, `11*(N+1)` cycles total; error responses are 11 cycles.
- **Start detection:** a glitch-free start is assumed; a start bit is any `sin=0` sampled in `IDLE`.
- **Arithmetic width:** computed at `DATA_W+1` bits; result truncated to `DATA_W`; no sign extension of operands.
- **Wrap-around:** ADD `0xFFFFFFFF+1` gives result 0 with carry = 1 and zero = 1.

## Test plan
1. `DATA_W=32`, ADD, B=`0x7FFFFFFF`, A=`0x00000001`, correct CRC -> result `0x80000000`, flags `0101` (ovfl, neg), 55-cycle response.
2. SUB, B=`0x00000003`, A=`0x00000005` -> result `0xFFFFFFFE`, flags `1001` (carry = borrow, neg), `crc3` matching the reference model.
3. Only 7 DATA frames before CTL -> error frame with payload `1_100_100_1`; no DATA frames output.
4. Valid frames with `crc4` bit 0 flipped -> payload `1_010_010_1`. With correct CRC and opcode `011` -> payload `1_001_001_1`.
5. `EN_XOR=0`, `DATA_W=8`, XOR opcode -> ERROP frame. With `EN_XOR=1`, B=`0xF0`, A=`0xFF` -> result `0x0F`, flags `0000`, 22-cycle response.
6. `rst_n` pulsed low mid-way through the 5th operand frame -> `sout` goes to 1 asynchronously. A following full valid AND of `0xFFFF0000` & `0x00FFFF00` -> result `0x00FF0000`, flags `0000`.
